// File: rtl/hctrl_encoder_if.sv
// hctrl_encoder_if: raw joystick inputs and the encoded Aquarius hand-controller
// bytes for NUM_PADS pads, eight bits per pad in matching slice layout.
interface hctrl_encoder_if #(
    parameter int NUM_PADS = 2
);
    logic [8*NUM_PADS-1:0] joy_in;
    logic [8*NUM_PADS-1:0] pad_out;
    logic [NUM_PADS-1:0]   pad_chg;

    modport master (output joy_in, input pad_out, input pad_chg);
    modport slave  (input joy_in, output pad_out, output pad_chg);
endinterface

// File: rtl/hctrl_encoder.sv
// hctrl_encoder: converts raw joystick bits into active-low Aquarius
// hand-controller bytes. Per pad: 2-flop synchroniser, debounce (candidate byte
// plus stable counter), direction/button encoding, registered output and a
// one-cycle change pulse.
// Optional feature: define HCTRL_AUTOFIRE_EN to gate button A with a shared
// square wave of half-period AF_HALF cycles (A reads as released on phase 0).
module hctrl_encoder #(
    parameter int NUM_PADS  = 2,
    parameter int DB_CYCLES = 16,
    parameter int AF_HALF   = 65536
) (
    input  logic           clk,
    input  logic           reset,
    hctrl_encoder_if.slave bus
);
    localparam int         PW      = 8 * NUM_PADS;
    localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

    localparam logic [7:0] CODE_A    = 8'hBF;
    localparam logic [7:0] CODE_B    = 8'h7B;
    localparam logic [7:0] CODE_X    = 8'h5F;
    localparam logic [7:0] CODE_Y    = 8'hDF;
    localparam logic [7:0] CODE_NONE = 8'hFF;

    // Elaboration-time guard on the legal parameter ranges.
    if (NUM_PADS < 1 || NUM_PADS > 4) begin : g_bad_num_pads
        $error("hctrl_encoder: NUM_PADS must be 1..4");
    end
    if (DB_CYCLES < 1 || DB_CYCLES > 255) begin : g_bad_db_cycles
        $error("hctrl_encoder: DB_CYCLES must be 1..255");
    end
    if (AF_HALF < 2 || AF_HALF > 1048576) begin : g_bad_af_half
        $error("hctrl_encoder: AF_HALF must be 2..2^20");
    end

    // Direction mask: opposing directions on one axis cancel that axis,
    // one horizontal plus one vertical direction clear both bits (diagonal).
    function automatic logic [7:0] dir_mask(input logic [7:0] b);
        logic [7:0] h_m;
        logic [7:0] v_m;
        case ({b[1], b[0]})
            2'b01:   h_m = 8'hFD;   // right only
            2'b10:   h_m = 8'hF7;   // left only
            default: h_m = 8'hFF;   // none, or both cancel
        endcase
        case ({b[3], b[2]})
            2'b01:   v_m = 8'hFE;   // down only
            2'b10:   v_m = 8'hFB;   // up only
            default: v_m = 8'hFF;   // none, or both cancel
        endcase
        return h_m & v_m;
    endfunction

    // Button mask: only the highest-priority pressed button (A > B > X > Y).
    function automatic logic [7:0] button_mask(input logic [7:0] b, input logic a_en);
        logic [7:0] m;
        if (b[4] && a_en) begin
            m = CODE_A;
        end else if (b[5]) begin
            m = CODE_B;
        end else if (b[6]) begin
            m = CODE_X;
        end else if (b[7]) begin
            m = CODE_Y;
        end else begin
            m = CODE_NONE;
        end
        return m;
    endfunction

    logic [PW-1:0]             sync1_r;
    logic [PW-1:0]             sync2_r;
    logic [NUM_PADS-1:0][7:0]  cand_r;
    logic [NUM_PADS-1:0][7:0]  cnt_r;
    logic [NUM_PADS-1:0][7:0]  stable_r;
    logic [PW-1:0]             pad_next_s;
    logic [NUM_PADS-1:0]       chg_next_s;
    logic [PW-1:0]             pad_out_r;
    logic [NUM_PADS-1:0]       pad_chg_r;
    logic                      af_phase_s;

`ifdef HCTRL_AUTOFIRE_EN
    localparam int              AF_W    = $clog2(AF_HALF);
    localparam logic [AF_W-1:0] AF_LAST = AF_W'(AF_HALF - 1);

    logic [AF_W-1:0] af_cnt_r;
    logic            af_phase_r;

    // Free-running autofire timer; the phase flips every AF_HALF cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            af_cnt_r   <= {AF_W{1'b0}};
            af_phase_r <= 1'b1;
        end else if (af_cnt_r == AF_LAST) begin
            af_cnt_r   <= {AF_W{1'b0}};
            af_phase_r <= ~af_phase_r;
        end else begin
            af_cnt_r   <= af_cnt_r + AF_W'(1);
        end
    end

    assign af_phase_s = af_phase_r;
`else
    // Without autofire, button A is always honoured.
    assign af_phase_s = 1'b1;
`endif

    // Two-flop synchroniser on every raw joystick bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= {PW{1'b0}};
            sync2_r <= {PW{1'b0}};
        end else begin
            sync1_r <= bus.joy_in;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: a changed byte restarts the count; a count of DB_CYCLES-1
    // with no further change promotes the candidate to the stable byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < NUM_PADS; n++) begin
                cand_r[n]   <= 8'h00;
                cnt_r[n]    <= 8'h00;
                stable_r[n] <= 8'h00;
            end
        end else begin
            for (int n = 0; n < NUM_PADS; n++) begin
                if (sync2_r[8*n +: 8] != cand_r[n]) begin
                    cand_r[n] <= sync2_r[8*n +: 8];
                    cnt_r[n]  <= 8'h00;
                end else if (cnt_r[n] == DB_LAST) begin
                    // Counter holds here until the next change.
                    stable_r[n] <= cand_r[n];
                end else begin
                    cnt_r[n] <= cnt_r[n] + 8'h01;
                end
            end
        end
    end

    // Encode each stable byte and flag slices whose encoded value differs.
    always_comb begin
        pad_next_s = {PW{1'b1}};
        chg_next_s = {NUM_PADS{1'b0}};
        for (int n = 0; n < NUM_PADS; n++) begin
            pad_next_s[8*n +: 8] = dir_mask(stable_r[n]) & button_mask(stable_r[n], af_phase_s);
            chg_next_s[n]        = (pad_next_s[8*n +: 8] != pad_out_r[8*n +: 8]);
        end
    end

    // Registered outputs; the change pulse lands on the cycle the new byte appears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pad_out_r <= {PW{1'b1}};
            pad_chg_r <= {NUM_PADS{1'b0}};
        end else begin
            pad_out_r <= pad_next_s;
            pad_chg_r <= chg_next_s;
        end
    end

    assign bus.pad_out = pad_out_r;
    assign bus.pad_chg = pad_chg_r;

endmodule

// File: tb/tb_hctrl_encoder.sv
// tb_hctrl_encoder: table-driven vectors, hand sequences for latency, glitch and
// reset corners, and randomized stimulus against a sample-history reference model.
module tb_hctrl_encoder;
    localparam int NP  = 2;
    localparam int DB  = 16;
    localparam int AF  = 4;
    localparam int LAT = DB + 3;

    logic clk = 1'b0;
    logic reset;

    hctrl_encoder_if #(.NUM_PADS(NP)) bus ();

    hctrl_encoder #(
        .NUM_PADS  (NP),
        .DB_CYCLES (DB),
        .AF_HALF   (AF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model state: every joy_in word sampled since reset release.
    logic [15:0] hist [$];
    logic [7:0]  stable_m [NP];
    logic [15:0] exp_out;
    logic [1:0]  exp_chg;
    int          edge_m;

    typedef struct {
        logic [7:0] j0;
        logic [7:0] j1;
        logic [7:0] e0;
        logic [7:0] e1;
        int         pulses;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Encoding from the rules, using signed axis arithmetic.
    function automatic logic [7:0] ref_encode(input logic [7:0] b, input bit phase);
        logic [7:0] r;
        int h;
        int v;
        r = 8'hFF;
        h = int'(b[0]) - int'(b[1]);
        v = int'(b[3]) - int'(b[2]);
        if (h == 1)  r[1] = 1'b0;
        if (h == -1) r[3] = 1'b0;
        if (v == 1)  r[2] = 1'b0;
        if (v == -1) r[0] = 1'b0;
        if (b[4] && phase) r = r & 8'hBF;
        else if (b[5])     r = r & 8'h7B;
        else if (b[6])     r = r & 8'h5F;
        else if (b[7])     r = r & 8'hDF;
        return r;
    endfunction

    function automatic logic [7:0] sample_byte(input int k, input int n);
        logic [15:0] w;
        if (k < 0) return 8'h00;
        w = hist[k];
        return w[8*n +: 8];
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int n = 0; n < NP; n++) stable_m[n] = 8'h00;
        exp_out = 16'hFFFF;
        exp_chg = 2'b00;
        edge_m  = 0;
    endtask

    // One rising edge of the model. A byte is accepted once DB+1 consecutive
    // synchronised samples (joy_in taken 2..DB+2 edges ago) agree; the encoded
    // byte registers one edge after acceptance.
    task automatic model_edge();
        logic [15:0] nxt;
        logic [7:0]  v;
        bit          ph;
        bit          same;
`ifdef HCTRL_AUTOFIRE_EN
        ph = ((edge_m / AF) % 2) == 0;
`else
        ph = 1'b1;
`endif
        for (int n = 0; n < NP; n++) nxt[8*n +: 8] = ref_encode(stable_m[n], ph);
        for (int n = 0; n < NP; n++) exp_chg[n] = (nxt[8*n +: 8] != exp_out[8*n +: 8]);
        exp_out = nxt;
        for (int n = 0; n < NP; n++) begin
            v    = sample_byte(edge_m - 2, n);
            same = 1'b1;
            for (int i = 1; i <= DB; i++) begin
                if (sample_byte(edge_m - 2 - i, n) != v) same = 1'b0;
            end
            if (same) stable_m[n] = v;
        end
        hist.push_back(bus.joy_in);
        edge_m++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("pad_out", 32'(bus.pad_out), 32'(exp_out));
        check("pad_chg", 32'(bus.pad_chg), 32'(exp_chg));
    endtask

    // Steps n cycles, returning the first step index where pad0 shows target.
    task automatic measure(input logic [7:0] target, input int n, output int first, output int pulses);
        first  = -1;
        pulses = 0;
        for (int e = 0; e < n; e++) begin
            step();
            if (bus.pad_chg[0]) pulses++;
            if (first < 0 && bus.pad_out[7:0] == target) first = e;
        end
    endtask

    function automatic bit has_a(input int t);
        return tbl[t].j0[4] || tbl[t].j1[4];
    endfunction

    initial begin
        int   first;
        int   pulses;
        bit   af_skip;
        bit   moved;
        int   hold;

        tbl[0]  = '{8'h09, 8'h00, 8'hF9, 8'hFF, 1};
        tbl[1]  = '{8'h00, 8'h00, 8'hFF, 8'hFF, 1};
        tbl[2]  = '{8'h03, 8'h00, 8'hFF, 8'hFF, 0};
        tbl[3]  = '{8'h21, 8'h00, 8'h79, 8'hFF, 1};
        tbl[4]  = '{8'h31, 8'h00, 8'hBD, 8'hFF, 1};
        tbl[5]  = '{8'h40, 8'h80, 8'h5F, 8'hDF, 1};
        tbl[6]  = '{8'h0C, 8'h20, 8'hFF, 8'h7B, 1};
        tbl[7]  = '{8'h06, 8'h30, 8'hF6, 8'hBF, 1};
        tbl[8]  = '{8'hC0, 8'h05, 8'h5F, 8'hFC, 1};
        tbl[9]  = '{8'h0F, 8'h00, 8'hFF, 8'hFF, 1};
        tbl[10] = '{8'h81, 8'h0A, 8'hDD, 8'hF3, 1};
        tbl[11] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 1};

        reset       = 1'b1;
        bus.joy_in  = 16'h0000;
        model_reset();
        #2;
        check("reset_pad_out", 32'(bus.pad_out), 32'h0000FFFF);
        check("reset_pad_chg", 32'(bus.pad_chg), 32'h0);
        repeat (2) @(posedge clk);
        #1;

        // Right held on pad0 across reset release.
        bus.joy_in = 16'h0001;
        reset      = 1'b0;
        model_reset();
        measure(8'hFD, LAT + 6, first, pulses);
        check("latency", 32'(first), 32'(LAT));
        check("latency_pulses", 32'(pulses), 32'd1);
        check("pad1_idle", 32'(bus.pad_out[15:8]), 32'hFF);

        // Table of steady-state encodings.
        for (int t = 0; t < 12; t++) begin
            bus.joy_in = {tbl[t].j1, tbl[t].j0};
            pulses = 0;
            for (int c = 0; c < LAT + 4; c++) begin
                step();
                if (bus.pad_chg[0]) pulses++;
            end
`ifdef HCTRL_AUTOFIRE_EN
            af_skip = has_a(t) || (t > 0 && has_a(t - 1));
`else
            af_skip = 1'b0;
`endif
            if (!af_skip) begin
                check($sformatf("tbl%0d_pad0", t), 32'(bus.pad_out[7:0]), 32'(tbl[t].e0));
                check($sformatf("tbl%0d_pad1", t), 32'(bus.pad_out[15:8]), 32'(tbl[t].e1));
                check($sformatf("tbl%0d_pulses", t), 32'(pulses), 32'(tbl[t].pulses));
            end
        end

        // 10-cycle glitch of button A must never be accepted.
        bus.joy_in = 16'h0010;
        moved  = 1'b0;
        pulses = 0;
        for (int c = 0; c < 10; c++) step();
        bus.joy_in = 16'h0000;
        for (int c = 0; c < LAT + 6; c++) begin
            step();
            if (bus.pad_chg[0]) pulses++;
            if (bus.pad_out[7:0] != 8'hFF) moved = 1'b1;
        end
        check("glitch_pulses", 32'(pulses), 32'd0);
        check("glitch_moved", 32'(moved), 32'd0);

        // Reset five cycles into a debounce, with a non-idle output showing.
        bus.joy_in = 16'h0002;
        for (int c = 0; c < LAT + 2; c++) step();
        check("pre_reset_left", 32'(bus.pad_out[7:0]), 32'hF7);
        bus.joy_in = 16'h0001;
        for (int c = 0; c < 5; c++) step();
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_out", 32'(bus.pad_out), 32'h0000FFFF);
        check("async_reset_chg", 32'(bus.pad_chg), 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        measure(8'hFD, LAT + 6, first, pulses);
        check("reset_relatency", 32'(first), 32'(LAT));
        check("reset_relatency_pulses", 32'(pulses), 32'd1);

`ifdef HCTRL_AUTOFIRE_EN
        // A+X held: output alternates between A and X codes.
        bus.joy_in = 16'h0050;
        for (int c = 0; c < LAT + 24; c++) step();
`endif

        // Randomized segments: mixed short glitches and accepted holds.
        for (int s = 0; s < 150; s++) begin
            if ($urandom_range(0, 2) == 0) begin
                bus.joy_in = bus.joy_in ^ (16'h0001 << $urandom_range(0, 15));
            end else begin
                bus.joy_in = 16'($urandom);
            end
            hold = $urandom_range(1, DB + 8);
            for (int c = 0; c < hold; c++) step();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/hctrl_encoder.md
HCTRL_ENCODER -- requirements
Module: hctrl_encoder

Interface
REQ-001 Parameter NUM_PADS, default 2: number of independent hand-controller channels, legal range 1..4.
REQ-002 Parameter DB_CYCLES, default 16: consecutive stable cycles required before a raw input change is accepted, legal range 1..255.
REQ-003 Parameter AF_HALF, default 65536: autofire half-period in clk cycles, legal range 2..2^20.
REQ-004 clk  in  1  system clock; every register in the block uses its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 joy_in  in  8*NUM_PADS  raw joystick bits; pad n occupies [8n+7:8n]; bit0 right, bit1 left, bit2 down, bit3 up, bit4 A, bit5 B, bit6 X, bit7 Y; 1 means pressed.
REQ-007 pad_out  out  8*NUM_PADS  active-low Aquarius hand-controller bytes, same slice layout as joy_in.
REQ-008 pad_chg  out  NUM_PADS  one-cycle pulse for each pad whose pad_out slice changed value.

Function
REQ-009 Each pad SHALL be processed independently; only the autofire phase counter is shared.
REQ-010 joy_in SHALL pass through a 2-flop synchroniser per bit.
REQ-011 Per pad, the block SHALL keep a candidate byte and a debounce counter; any synchronised value differing from the candidate loads the candidate and clears the counter.
REQ-012 When the counter reaches DB_CYCLES-1 with no change, the stable byte SHALL load the candidate; the counter saturates until the next change.
REQ-013 Glitches shorter than DB_CYCLES cycles SHALL never reach the stable byte.
REQ-014 Direction mask from the stable byte: start 8'hFF; right clears bit1; left clears bit3; down clears bit0; up clears bit2.
REQ-015 Right+left both pressed SHALL cancel the horizontal axis, and up+down both pressed SHALL cancel the vertical axis.
REQ-016 One horizontal plus one vertical direction SHALL clear both bits to form a diagonal (e.g. up+right = 8'hF9).
REQ-017 Button mask: only the highest-priority pressed button contributes, priority A > B > X > Y, with codes A = 8'hBF, B = 8'h7B, X = 8'h5F, Y = 8'hDF; no button gives 8'hFF.
REQ-018 The pad_out slice SHALL be registered as direction mask AND button mask, so a direction and a button may be reported together.
REQ-019 An input step held stable SHALL appear on pad_out exactly DB_CYCLES+3 cycles after the edge on which joy_in was sampled.
REQ-020 pad_chg[n] SHALL be high on the cycle that slice n of pad_out first shows a new value, and low otherwise.
REQ-021 An input that toggles back before acceptance SHALL produce no pad_chg pulse.

Reset
REQ-022 While reset is high, pad_out SHALL be all 8'hFF and pad_chg all 0, taking effect asynchronously.
REQ-023 While reset is high, synchroniser flops, candidate bytes, stable bytes and counters SHALL be 0, and the autofire phase SHALL be 1 (fire enabled).
REQ-024 Reset asserted mid-debounce SHALL discard the pending value.
REQ-025 Inputs held pressed across reset release SHALL be reported only after the full DB_CYCLES+3 latency.

Configuration
REQ-026 With macro HCTRL_AUTOFIRE_EN defined, a free-running counter SHALL toggle the autofire phase every AF_HALF cycles.
REQ-027 With HCTRL_AUTOFIRE_EN defined, stable button A SHALL be treated as released while the phase is 0, so lower-priority buttons may then win.
REQ-028 Without HCTRL_AUTOFIRE_EN, no counter or phase logic SHALL exist, A SHALL pass unmodified, and AF_HALF SHALL be ignored.

Verification
REQ-029 Reset release, joy_in pad0 = 8'h01 held -> pad_out[7:0] = 8'hFD at cycle DB_CYCLES+3, one pad_chg[0] pulse, pad1 stays 8'hFF.
REQ-030 Pad0 = 8'h09 (right+up) -> 8'hF9; pad0 = 8'h03 (right+left) -> 8'hFF with no pad_chg pulse.
REQ-031 Pad0 = 8'h21 (right+B) -> 8'h79; adding A (8'h31) -> 8'hBD.
REQ-032 DB_CYCLES=16, pad0 pulse 8'h10 lasting 10 cycles -> pad_out unchanged and no pad_chg pulse.
REQ-033 HCTRL_AUTOFIRE_EN defined, AF_HALF=4, pad0 = 8'h50 (A+X) held -> pad_out alternates 8'hBF and 8'h5F every 4 cycles, with a pad_chg pulse at each change.
REQ-034 Reset asserted 5 cycles into a debounce -> pad_out = 8'hFF immediately, and the value needs the full latency after release.
